// File: rtl/cordic_nco_ctrl.sv
// Phase-accumulator front end and result collector for a 16-stage CORDIC rotator.
// Issues angles under FIFO credit control and streams tagged CORDIC results downstream.
module cordic_nco_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LATENCY    = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int          AMPLITUDE  = 19890
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [31:0]      freq_word,
  input  logic [31:0]      phase_offset,
  output logic [WIDTH-1:0] cordic_x_start,
  output logic [WIDTH-1:0] cordic_y_start,
  output logic [31:0]      cordic_angle,
  input  logic [WIDTH-1:0] cordic_cos,
  input  logic [WIDTH-1:0] cordic_sin,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_cos,
  output logic [WIDTH-1:0] m_sin,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_t             state;
  logic [31:0]        phase_acc;
  logic [LATENCY:0]   tags;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW:0]        credit_used;
  logic               issue;
  logic               push;
  logic               pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every issued sample owns a FIFO slot until popped, so pushes can never be refused.
  assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
  assign issue          = (state == RUN) && enable && (credit_used < (CW+1)'(FIFO_DEPTH));
  // The extra tag stage lines the push up with the edge after the CORDIC output settles.
  assign push           = tags[LATENCY];
  assign m_valid        = (fifo_count != '0);
  assign pop            = m_valid && m_ready;
  assign cordic_y_start = '0;
  assign m_cos          = m_valid ? mem[rd_ptr][2*WIDTH-1:WIDTH] : '0;
  assign m_sin          = m_valid ? mem[rd_ptr][WIDTH-1:0] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      phase_acc      <= '0;
      cordic_angle   <= '0;
      cordic_x_start <= '0;
      tags           <= '0;
      inflight       <= '0;
    end else begin
      tags <= {tags[LATENCY-1:0], issue};

      if (issue) begin
        cordic_angle   <= phase_acc + phase_offset;
        cordic_x_start <= WIDTH'(AMPLITUDE);
      end

      if (load) begin
        phase_acc <= '0;
      end else if (issue) begin
        phase_acc <= phase_acc + freq_word;
      end

      if (issue && !push) begin
        inflight <= inflight + 1'b1;
      end else if (!issue && push) begin
        inflight <= inflight - 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (inflight == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {cordic_cos, cordic_sin};
    end
  end

endmodule
